// File: rtl/vga_rx_pkg.sv
// vga_rx_pkg: shared constants, PMOD bit map and FSM state for the VGA PMOD receiver.
// Optional frame checksum is enabled by the VGA_RX_CHECKSUM_EN macro.
package vga_rx_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_TOTAL_DEF  = 800;
  localparam int H_START_DEF  = 144;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_TOTAL_DEF  = 525;
  localparam int V_START_DEF  = 35;

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam int PMOD_HS = 7;
  localparam int PMOD_B0 = 6;
  localparam int PMOD_G0 = 5;
  localparam int PMOD_R0 = 4;
  localparam int PMOD_VS = 3;
  localparam int PMOD_B1 = 2;
  localparam int PMOD_G1 = 1;
  localparam int PMOD_R1 = 0;

  // Both syncs deasserted (high), colour bits low.
  localparam logic [7:0] PMOD_IDLE = 8'h88;

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_MEASURE = 2'd1,
    S_LOCKED  = 2'd2
  } rx_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [5:0] pmod_rgb(
    input logic [7:0] p
  );
    return {p[PMOD_R1], p[PMOD_R0],
            p[PMOD_G1], p[PMOD_G0],
            p[PMOD_B1], p[PMOD_B0]};
  endfunction

endpackage

// File: rtl/vga_rx_edge_det.sv
// vga_rx_edge_det: holds the previous sync sample and flags its assert (1->0) edge.
// Build option VGA_RX_CHECKSUM_EN does not affect this block.
module vga_rx_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic fell
);

  logic q;

  // previous sample idles high so leaving reset never fakes an edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= 1'b1;
    end else begin
      q <= d;
    end
  end

  assign fell = q & ~d;

endmodule

// File: rtl/vga_pmod_receiver.sv
// vga_pmod_receiver: recovers pixels, coordinates and lock from a TinyVGA PMOD stream.
// Define VGA_RX_CHECKSUM_EN to add the per-frame pixel checksum on frame_sum/sum_valid.
module vga_pmod_receiver
  import vga_rx_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int H_START  = H_START_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF,
  parameter int V_START  = V_START_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pmod_in,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err,
  output logic [15:0] frame_sum,
  output logic        sum_valid
);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_OVER = 10'(H_TOTAL);
  localparam logic [9:0] H_LO   = 10'(H_START);
  localparam logic [9:0] H_HI   = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_LO   = 10'(V_START);
  localparam logic [9:0] V_HI   = 10'(V_START + V_ACTIVE);

  logic [7:0] pmod_q;
  logic       hs_fell;
  logic       vs_fell;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  rx_state_e  state_q;
  rx_state_e  state_d;
  logic       meas_bad_q;
  logic       meas_bad_d;
  logic       line_bad;
  logic       frame_bad;
  logic       err_d;
  logic       active;
  logic       valid_d;
  logic [9:0] x_d;
  logic [9:0] y_d;
  logic [5:0] rgb_d;

  // single input register; syncs park deasserted in reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pmod_q <= PMOD_IDLE;
    end else begin
      pmod_q <= pmod_in;
    end
  end

  vga_rx_edge_det u_hs (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pmod_q[PMOD_HS]),
    .fell  (hs_fell)
  );

  vga_rx_edge_det u_vs (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pmod_q[PMOD_VS]),
    .fell  (vs_fell)
  );

  // position of the sample now in pmod_q; a vsync clear beats the line step
  always_comb begin
    h_nxt = sat_inc(h_cnt);
    v_nxt = v_cnt;
    if (hs_fell) begin
      h_nxt = '0;
      v_nxt = sat_inc(v_cnt);
    end
    if (vs_fell) begin
      v_nxt = '0;
    end
  end

  // timing checks: line period at each edge, overlong line as soon as it overruns
  always_comb begin
    line_bad  = 1'b0;
    frame_bad = 1'b0;
    if (hs_fell) begin
      line_bad = (h_cnt != H_LAST);
    end else begin
      line_bad = (h_nxt == H_OVER);
    end
    if (vs_fell) begin
      frame_bad = (v_cnt != V_LAST);
    end else if (hs_fell) begin
      frame_bad = (v_cnt >= V_LAST);
    end
  end

  // lock FSM: next state, sticky measurement error and loss-of-lock pulse
  always_comb begin
    state_d    = state_q;
    meas_bad_d = meas_bad_q;
    err_d      = 1'b0;
    unique case (state_q)
      S_SEARCH: begin
        if (vs_fell) begin
          state_d    = S_MEASURE;
          meas_bad_d = 1'b0;
        end
      end
      S_MEASURE: begin
        if (vs_fell) begin
          if (!meas_bad_q && !line_bad && !frame_bad) begin
            state_d = S_LOCKED;
          end
          meas_bad_d = 1'b0;
        end else if (line_bad || frame_bad) begin
          meas_bad_d = 1'b1;
        end
      end
      S_LOCKED: begin
        if (line_bad || frame_bad) begin
          state_d = S_SEARCH;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_SEARCH;
      end
    endcase
  end

  // active-window decode; everything is zeroed outside a locked active pixel
  always_comb begin
    active = (h_nxt >= H_LO) && (h_nxt < H_HI) &&
             (v_nxt >= V_LO) && (v_nxt < V_HI);
    valid_d = active && (state_q == S_LOCKED);
    x_d     = '0;
    y_d     = '0;
    rgb_d   = '0;
    if (valid_d) begin
      x_d   = h_nxt - H_LO;
      y_d   = v_nxt - V_LO;
      rgb_d = pmod_rgb(pmod_q);
    end
  end

  // counters and FSM state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      state_q    <= S_SEARCH;
      meas_bad_q <= 1'b0;
    end else begin
      h_cnt      <= h_nxt;
      v_cnt      <= v_nxt;
      state_q    <= state_d;
      meas_bad_q <= meas_bad_d;
    end
  end

  // registered pixel and status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      pix_valid   <= valid_d;
      pix_x       <= x_d;
      pix_y       <= y_d;
      pix_rgb     <= rgb_d;
      frame_start <= valid_d && (x_d == '0) && (y_d == '0);
      locked      <= (state_d == S_LOCKED);
      sync_err    <= err_d;
    end
  end

`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] acc;
  logic        snap;
  logic        entry;

  assign snap  = vs_fell && (state_q == S_LOCKED);
  assign entry = (state_q != S_LOCKED) && (state_d == S_LOCKED);

  // sum emitted pixels; publish and restart at each locked frame boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      frame_sum <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= snap;
      if (snap) begin
        frame_sum <= acc;
        acc       <= '0;
      end else if (entry) begin
        acc <= '0;
      end else if (pix_valid) begin
        acc <= acc + {10'b0, pix_rgb};
      end
    end
  end
`else
  assign frame_sum = '0;
  assign sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_pmod_receiver.sv
// tb_vga_pmod_receiver: random and directed PMOD frames on a reduced raster,
// checked every cycle against a frame-level model of the stream.
module tb_vga_pmod_receiver;

  localparam int HA  = 16;
  localparam int HT  = 24;
  localparam int HS  = 6;
  localparam int VA  = 8;
  localparam int VT  = 12;
  localparam int VS  = 3;
  localparam int HSW = 3;
  localparam int VSW = 1;

  typedef struct packed {
    logic        v;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [5:0]  rgb;
    logic        fs;
    logic        lk;
    logic        er;
    logic [15:0] sum;
    logic        sv;
  } outv_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pmod_in = 8'h88;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [5:0]  pix_rgb;
  logic        frame_start;
  logic        locked;
  logic        sync_err;
  logic [15:0] frame_sum;
  logic        sum_valid;

  vga_pmod_receiver #(
    .H_ACTIVE (HA),
    .H_TOTAL  (HT),
    .H_START  (HS),
    .V_ACTIVE (VA),
    .V_TOTAL  (VT),
    .V_START  (VS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pmod_in     (pmod_in),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_rgb     (pix_rgb),
    .frame_start (frame_start),
    .locked      (locked),
    .sync_err    (sync_err),
    .frame_sum   (frame_sum),
    .sum_valid   (sum_valid)
  );

  always #5 clk = ~clk;

  int          n_asrt = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_err = 0;
  int          hits = 0;
  int          n_sv = 0;
  int          fs_cyc = -1;
  int          f0 = 0;
  logic [15:0] last_sum = '0;
  outv_t       pend = '0;
  int          m_good = 0;
  bit          m_lock = 1'b0;
`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] m_acc = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // drive one sample; check the outputs due from the previous one
  task automatic step(input logic [7:0] p, input outv_t e_new,
                      input bit do_rst);
    outv_t obs;
    outv_t exp_now;
    pmod_in = p;
    rst_n   = !do_rst;
    @(posedge clk);
    #1;
    obs = {pix_valid, pix_x, pix_y, pix_rgb, frame_start,
           locked, sync_err, frame_sum, sum_valid};
    exp_now = do_rst ? outv_t'(0) : pend;
    n_asrt++;
    assert (obs === exp_now) else begin
      n_fail++;
      $error("FAIL cyc%0d obs=%h exp=%h", cyc, obs, exp_now);
    end
    if (obs.er) n_err++;
    if (obs.v && obs.x == 10'd5 && obs.y == 10'd7 &&
        obs.rgb == 6'b100100) hits++;
    if (obs.fs) fs_cyc = cyc;
    if (obs.sv) begin
      n_sv++;
      last_sum = obs.sum;
    end
    pend = do_rst ? outv_t'(0) : e_new;
    cyc++;
  endtask

  // mode 0 random colour, 1 single lit pixel at (5,7), 2 all 3F
  task automatic drive_frame(input int mode, input int str_l,
                             input int rst_l, input int rst_o);
    for (int l = 0; l < VT; l++) begin
      for (int o = 0; o < ((l == str_l) ? HT + 1 : HT); o++) begin
        logic [5:0] c;
        logic [7:0] p;
        outv_t      e;
        bit         rst;
        c = 6'($urandom);
        if (mode == 1) c = (l == VS + 7 && o == HS + 5) ? 6'b100100 : 6'b0;
        if (mode == 2) c = 6'h3F;
        p = {o >= HSW, c[0], c[2], c[4], l >= VSW, c[1], c[3], c[5]};
        rst = (l == rst_l && o == rst_o);
        e = '0;
        if (l == 0 && o == 0) f0 = cyc;
        if (rst) begin
          m_lock = 1'b0;
          m_good = 0;
        end else begin
          if (l == 0 && o == 0) begin
`ifdef VGA_RX_CHECKSUM_EN
            if (m_lock) begin
              e.sv  = 1'b1;
              e.sum = m_acc;
            end
            m_acc = '0;
`endif
            m_good++;
            m_lock = (m_good >= 2);
          end
          if (l == str_l && o == HT) begin
            if (m_lock) e.er = 1'b1;
            m_lock = 1'b0;
            m_good = 0;
          end
          e.lk = m_lock;
          if (m_lock && o >= HS && o < HS + HA && l >= VS && l < VS + VA) begin
            e.v   = 1'b1;
            e.x   = 10'(o - HS);
            e.y   = 10'(l - VS);
            e.rgb = c;
            e.fs  = (o == HS && l == VS);
`ifdef VGA_RX_CHECKSUM_EN
            m_acc = m_acc + 16'(c);
`endif
          end
        end
        step(p, e, rst);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(8'h88, '0, 1'b1);
    chk("reset_locked", 32'(locked), 0);
    chk("reset_valid", 32'(pix_valid), 0);
    drive_frame(0, -1, -1, -1);
    chk("measure_unlocked", 32'(locked), 0);
    drive_frame(0, -1, -1, -1);
    chk("lock_2nd_vs", 32'(locked), 1);
    hits = 0;
    drive_frame(1, -1, -1, -1);
    chk("pix_5_7", hits, 1);
    chk("frame_start_ofs", fs_cyc - f0, VS * HT + HS + 1);
    drive_frame(0, 5, -1, -1);
    chk("err_once", n_err, 1);
    chk("lost_lock", 32'(locked), 0);
    drive_frame(0, -1, -1, -1);
    chk("remeasure", 32'(locked), 0);
    drive_frame(0, -1, -1, -1);
    chk("relock", 32'(locked), 1);
    drive_frame(2, -1, -1, -1);
    drive_frame(0, -1, 6, 10);
    chk("rst_unlocked", 32'(locked), 0);
    drive_frame(0, -1, -1, -1);
    chk("rst_measure", 32'(locked), 0);
    drive_frame(0, -1, -1, -1);
    chk("rst_relock", 32'(locked), 1);
    step(8'h88, '0, 1'b0);
    chk("err_total", n_err, 1);
`ifdef VGA_RX_CHECKSUM_EN
    chk("sum_count", n_sv, 4);
    chk("sum_3f", 32'(last_sum), (HA * VA * 63) % 65536);
`else
    chk("sum_count", n_sv, 0);
    chk("sum_zero", 32'(last_sum), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pmod_receiver.md
VGA_PMOD_RECEIVER -- requirements
Module: vga_pmod_receiver

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 SHALL have parameter H_TOTAL, default 800: clocks per line.
REQ-003 SHALL have parameter H_START, default 144: clocks from hsync-assert edge to first active pixel (sync 96 + back porch 48).
REQ-004 SHALL have parameter V_ACTIVE, default 480, and V_TOTAL, default 525: active and total lines per frame.
REQ-005 SHALL have parameter V_START, default 35: v_cnt value of the first active line.
REQ-006 SHALL have port clk  in  1  pixel clock, one pixel per cycle; all logic on rising edge.
REQ-007 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-008 SHALL have port pmod_in  in  8  TinyVGA PMOD: bit7 hsync, 6 B0, 5 G0, 4 R0, 3 vsync, 2 B1, 1 G1, 0 R1; syncs active-low.
REQ-009 SHALL have port pix_valid  out  1  decoded active pixel present.
REQ-010 SHALL have ports pix_x  out  10  and pix_y  out  10: pixel coordinates.
REQ-011 SHALL have port pix_rgb  out  6  pixel colour {R1,R0,G1,G0,B1,B0}.
REQ-012 SHALL have port frame_start  out  1  one-cycle pulse coincident with pixel (0,0).
REQ-013 SHALL have port locked  out  1  timing lock status.
REQ-014 SHALL have port sync_err  out  1  one-cycle pulse on loss of lock.
REQ-015 SHALL have ports frame_sum  out  16 and sum_valid  out  1: frame checksum and its one-cycle strobe.

Function
REQ-016 SHALL register pmod_in once; pix_* outputs SHALL be registered, giving exactly 2 cycles latency from pmod_in to pix_*.
REQ-017 SHALL detect a sync assert edge as a 1->0 transition between consecutive registered samples.
REQ-018 h_cnt SHALL clear to 0 on an hsync-assert edge and otherwise increment, saturating at 1023.
REQ-019 v_cnt SHALL clear to 0 on a vsync-assert edge and otherwise increment on each hsync-assert edge, saturating at 1023; if both edges occur in the same cycle, the clear wins.
REQ-020 Pixel active iff H_START <= h_cnt < H_START+H_ACTIVE and V_START <= v_cnt < V_START+V_ACTIVE; then pix_x = h_cnt-H_START and pix_y = v_cnt-V_START.
REQ-021 pix_valid SHALL assert only for active pixels while locked=1; when pix_valid=0, pix_x, pix_y and pix_rgb SHALL be 0.
REQ-022 FSM states SHALL be SEARCH, MEASURE and LOCKED; locked=1 only in LOCKED.
REQ-023 SEARCH -> MEASURE on a vsync-assert edge.
REQ-024 MEASURE -> LOCKED at the next vsync-assert edge if every hsync-assert-to-hsync-assert period was exactly H_TOTAL clocks and exactly V_TOTAL hsync edges occurred; otherwise MEASURE -> MEASURE, restarting the measurement.
REQ-025 In LOCKED, a line period != H_TOTAL or a frame line count != V_TOTAL SHALL pulse sync_err for one cycle and go to SEARCH; sync_err SHALL never pulse outside LOCKED.
REQ-026 A line period is checked at each hsync-assert edge; a period exceeding H_TOTAL SHALL be flagged at count H_TOTAL+1 without waiting for the edge.
REQ-027 Arithmetic SHALL be unsigned; counters SHALL never wrap.

Reset
REQ-028 When rst_n=0 at a clock edge: state=SEARCH, counters=0, all outputs 0, and sync sample registers set to 1 (deasserted) so that no false edge is seen after reset.
REQ-029 Reset mid-frame SHALL abandon the frame; re-lock SHALL follow REQ-023/024.

Configuration
REQ-030 Macro VGA_RX_CHECKSUM_EN: when defined, a 16-bit accumulator adds {10'b0,pix_rgb} mod 2^16 on each pix_valid cycle.
REQ-031 With VGA_RX_CHECKSUM_EN defined, at each vsync-assert edge in LOCKED the accumulator SHALL be copied to frame_sum, sum_valid SHALL pulse and the accumulator SHALL clear; the accumulator SHALL also clear on entry to LOCKED.
REQ-032 Without VGA_RX_CHECKSUM_EN, frame_sum=0 and sum_valid=0 constantly, and no accumulator logic SHALL exist.

Structure
REQ-033 Package vga_rx_pkg SHALL hold the default timing constants, the PMOD bit indices and the FSM state enum.
REQ-034 Sub-module vga_rx_edge_det (sample register, assert-edge pulse, reset to 1) SHALL be instantiated once each for hsync and vsync.

Verification
REQ-035 Reset, then clean 640x480@800x525 stream -> locked=1 at the second vsync-assert edge; sync_err never pulses.
REQ-036 Locked; drive R1=1, G0=1 at source pixel (5,7) -> pix_valid=1, pix_x=5, pix_y=7, pix_rgb=6'b100100 two cycles later.
REQ-037 Locked; one line stretched to 801 clocks -> sync_err pulses once at count 801, locked=0, pix_valid stays 0 until re-lock.
REQ-038 VGA_RX_CHECKSUM_EN defined, all pixels 6'h3F for one locked frame -> sum_valid pulse with frame_sum=16'h5000.
REQ-039 rst_n low for 1 cycle mid-frame -> all outputs 0 on the next cycle; locked=1 again after two further vsync-assert edges.
REQ-040 hsync and vsync asserted in the same cycle -> v_cnt=0 (not 1), and frame_start pulses V_START lines later at h_cnt=H_START.
